draw_sequencer: RTL

//  Frame-level draw scheduler between the game control logic and the VGA adapter.
//  On each frame_tick it enables draw clients one at a time, in fixed index order:
//  0 = background, 1 = HUD, 2 = link sprite, 3 = enemies.
//  It runs the enable/draw_done/draw_ack handshake with each client and muxes the

---
 rtl/draw_sequencer_pkg.sv | 36 +++
 rtl/draw_sequencer_if.sv | 39 +++
 rtl/draw_sequencer_pixel_mux.sv | 57 +++++
 rtl/draw_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/draw_sequencer_pkg.sv
// Shared widths, client indices, FSM encoding and pixel payload for the draw sequencer.
package draw_pkg;

    localparam int unsigned X_W   = 9;
    localparam int unsigned Y_W   = 8;
    localparam int unsigned COL_W = 3;

    // Fixed draw order within a pass: lowest index is drawn first.
    localparam int unsigned CL_BG    = 0;
    localparam int unsigned CL_HUD   = 1;
    localparam int unsigned CL_LINK  = 2;
    localparam int unsigned CL_ENEMY = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pixel_t;

    // Bits needed to hold values 0..count-1, never less than one bit.
    function automatic int unsigned width_of(input int unsigned count);
        int unsigned w;
        w = 1;
        if (count > 1) begin
            w = int'($clog2(count));
        end
        return w;
    endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Bus between the draw sequencer, its draw clients and the VGA adapter.
interface draw_sequencer_if #(
    parameter int unsigned N = 4
);
    import draw_pkg::*;

    logic                 frame_tick;
    logic [N-1:0]         client_done;
    logic [N-1:0]         client_write;
    logic [X_W*N-1:0]     client_x;
    logic [Y_W*N-1:0]     client_y;
    logic [COL_W*N-1:0]   client_colour;

    logic [N-1:0]         client_enable;
    logic [N-1:0]         client_ack;
    logic [X_W-1:0]       vga_x;
    logic [Y_W-1:0]       vga_y;
    logic [COL_W-1:0]     vga_colour;
    logic                 vga_write;
    logic                 frame_busy;
    logic                 frame_done;
    logic                 frame_overrun;
    logic                 client_timeout;

    // Sequencer side.
    modport master (
        input  frame_tick, client_done, client_write, client_x, client_y, client_colour,
        output client_enable, client_ack, vga_x, vga_y, vga_colour, vga_write,
               frame_busy, frame_done, frame_overrun, client_timeout
    );

    // Client / control side.
    modport slave (
        output frame_tick, client_done, client_write, client_x, client_y, client_colour,
        input  client_enable, client_ack, vga_x, vga_y, vga_colour, vga_write,
               frame_busy, frame_done, frame_overrun, client_timeout
    );

endinterface

// File: rtl/draw_sequencer_pixel_mux.sv
// Registered N:1 pixel select; outputs a quiet (zero) pixel whenever no client is active.
module draw_pixel_mux
    import draw_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_active,
    input  logic [IDX_W-1:0]              i_idx,
    input  logic [NUM_CLIENTS-1:0]        i_write,
    input  logic [X_W*NUM_CLIENTS-1:0]    i_x,
    input  logic [Y_W*NUM_CLIENTS-1:0]    i_y,
    input  logic [COL_W*NUM_CLIENTS-1:0]  i_colour,
    output logic [X_W-1:0]                o_x,
    output logic [Y_W-1:0]                o_y,
    output logic [COL_W-1:0]              o_colour,
    output logic                          o_write
);

    pixel_t w_sel_pixel;
    logic   w_sel_write;
    pixel_t r_pixel;
    logic   r_write;

    // Pick the indexed client's pixel and write strobe.
    always_comb begin
        w_sel_pixel = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            if (i_idx == IDX_W'(i)) begin
                w_sel_pixel.x      = i_x[X_W*i +: X_W];
                w_sel_pixel.y      = i_y[Y_W*i +: Y_W];
                w_sel_pixel.colour = i_colour[COL_W*i +: COL_W];
                w_sel_write        = i_write[i];
            end
        end
    end

    // One-cycle pipeline stage toward the VGA adapter.
    always_ff @(posedge i_clock) begin
        if (i_reset || !i_active) begin
            r_pixel <= '0;
            r_write <= 1'b0;
        end else begin
            r_pixel <= w_sel_pixel;
            r_write <= w_sel_write;
        end
    end

    assign o_x      = r_pixel.x;
    assign o_y      = r_pixel.y;
    assign o_colour = r_pixel.colour;
    assign o_write  = r_write;

endmodule

// File: rtl/draw_sequencer.sv
// Frame draw scheduler: walks the clients in index order once per frame tick,
// runs the enable / done / ack handshake and forwards the active client's pixels.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 131072
) (
    input  logic              i_clock,
    input  logic              i_reset,
    draw_sequencer_if.master  bus
);

    localparam int unsigned IDX_W = width_of(NUM_CLIENTS);
    localparam int unsigned WD_W  = width_of(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [WD_W-1:0]        WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = NUM_CLIENTS'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic [IDX_W-1:0]         w_idx_inc;
    logic [WD_W-1:0]          r_wdog;
    logic [WD_W-1:0]          w_wdog_nxt;
    logic                     w_wdog_hit;
    logic                     w_sel_done;

    logic [NUM_CLIENTS-1:0]   r_enable;
    logic [NUM_CLIENTS-1:0]   w_enable_nxt;
    logic [NUM_CLIENTS-1:0]   r_ack;
    logic [NUM_CLIENTS-1:0]   w_ack_nxt;
    logic                     r_busy;
    logic                     w_busy_nxt;
    logic                     r_done;
    logic                     w_done_nxt;
    logic                     r_overrun;
    logic                     w_overrun_nxt;
    logic                     r_timeout;
    logic                     w_timeout_nxt;

    logic                     w_mux_active;
    logic [X_W-1:0]           w_vga_x;
    logic [Y_W-1:0]           w_vga_y;
    logic [COL_W-1:0]         w_vga_colour;
    logic                     w_vga_write;

    assign w_idx_inc    = r_idx + IDX_W'(1);
    assign w_wdog_hit   = (r_wdog == WD_MAX);
    assign w_mux_active = (r_state == S_DRAW);

    // Done flag of the active client only; other clients' done flags are ignored.
    always_comb begin
        w_sel_done = 1'b0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_done = bus.client_done[i];
            end
        end
    end

    // State, index, watchdog and status registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_wdog    <= '0;
            r_enable  <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_wdog    <= w_wdog_nxt;
            r_enable  <= w_enable_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next state plus the next value of every registered handshake/status output,
    // so enable/ack line up exactly with the S_DRAW/S_ACK cycles.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_wdog_nxt    = r_wdog;
        w_enable_nxt  = '0;
        w_ack_nxt     = '0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = r_overrun | (bus.frame_tick && (r_state != S_IDLE));
        w_timeout_nxt = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (bus.frame_tick) begin
                    w_state_nxt  = S_DRAW;
                    w_idx_nxt    = '0;
                    w_wdog_nxt   = '0;
                    w_enable_nxt = ONE_HOT0;
                    w_busy_nxt   = 1'b1;
                end
            end
            S_DRAW: begin
                w_busy_nxt = 1'b1;
                if (w_sel_done || w_wdog_hit) begin
                    w_state_nxt = S_ACK;
                    w_wdog_nxt  = '0;
                    w_ack_nxt   = ONE_HOT0 << r_idx;
                    if (!w_sel_done) begin
                        w_timeout_nxt = 1'b1;
                    end
                end else begin
                    w_wdog_nxt   = r_wdog + WD_W'(1);
                    w_enable_nxt = ONE_HOT0 << r_idx;
                end
            end
            S_ACK: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt  = S_DRAW;
                    w_idx_nxt    = w_idx_inc;
                    w_enable_nxt = ONE_HOT0 << w_idx_inc;
                    w_busy_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
                w_wdog_nxt  = '0;
            end
        endcase
    end

    draw_pixel_mux #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_pixel_mux (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_active (w_mux_active),
        .i_idx    (r_idx),
        .i_write  (bus.client_write),
        .i_x      (bus.client_x),
        .i_y      (bus.client_y),
        .i_colour (bus.client_colour),
        .o_x      (w_vga_x),
        .o_y      (w_vga_y),
        .o_colour (w_vga_colour),
        .o_write  (w_vga_write)
    );

    assign bus.client_enable  = r_enable;
    assign bus.client_ack     = r_ack;
    assign bus.frame_busy     = r_busy;
    assign bus.frame_done     = r_done;
    assign bus.frame_overrun  = r_overrun;
    assign bus.client_timeout = r_timeout;
    assign bus.vga_x          = w_vga_x;
    assign bus.vga_y          = w_vga_y;
    assign bus.vga_colour     = w_vga_colour;
    assign bus.vga_write      = w_vga_write;

endmodule
